// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Purpose  : Bit-serial unsigned subtractor. Computes d = (a - b) mod 2^WIDTH
//            one bit per clock, LSB first, using a full subtractor built from
//            two half subtractors. A request takes WIDTH+2 cycles start to
//            start: one load edge, WIDTH RUN edges, one DONE edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start_i  in   request pulse, only honoured in IDLE
//   a_i      in   WIDTH-bit minuend, captured on the accepted start edge
//   b_i      in   WIDTH-bit subtrahend, captured on the accepted start edge
//   busy_o   out  high while an operation is in RUN or DONE
//   done_o   out  one-cycle pulse, d_o/bout_o are valid
//   d_o      out  WIDTH-bit difference, held until the next accepted start
//   bout_o   out  final borrow (1 iff a < b unsigned)
//   ovf_o    out  signed overflow flag (only with SERIAL_SUB_OVF_EN)
// ----------------------------------------------------------------------------
// Configuration macro
//   SERIAL_SUB_OVF_EN : when defined, adds ovf_o and the operand-MSB capture
//                       flops that feed it.
// ============================================================================
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  // Counter must be able to index WIDTH RUN edges (0..WIDTH-1).
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;

  // Full subtractor as two cascaded half subtractors.
  logic hs1_diff, hs1_borrow;
  logic fs_diff, hs2_borrow, br_next;
  logic [WIDTH-1:0] res_full;

  assign hs1_diff   = a_sh_q[0] ^ b_sh_q[0];
  assign hs1_borrow = ~a_sh_q[0] & b_sh_q[0];
  assign fs_diff    = hs1_diff ^ br_q;
  assign hs2_borrow = ~hs1_diff & br_q;
  assign br_next    = hs1_borrow | hs2_borrow;

  // Result register with the current diff bit shifted in at the MSB; on the
  // final RUN edge this is the complete difference.
  assign res_full = WIDTH'({fs_diff, res_q} >> 1);

`ifdef SERIAL_SUB_OVF_EN
  // The operand registers shift away their MSBs, so keep copies for ovf.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
`endif
        end
      end

      S_RUN: begin
        res_d  = res_full;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          d_d     = res_full;
          bout_d  = br_next;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // fs_diff is the result MSB on this edge.
          ovf_d = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = d_q;
  assign bout_o = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Purpose  : Scoreboard bench for serial_sub (WIDTH=8). Stimulus pushes the
//            hand-computed result and the cycle at which done must appear;
//            a monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// Macro    : SERIAL_SUB_OVF_EN also enables the ovf_o comparisons.
// ============================================================================
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] d_o;
  logic             bout_o;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_o;
`endif

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .d_o     (d_o),
    .bout_o  (bout_o)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: done at cycle %0d with empty scoreboard", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("d", 32'(d_o), 32'(e.d));
        chk("bout", 32'(bout_o), 32'(e.bout));
        chk("busy_in_done", 32'(busy_o), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf_o), 32'(e.ovf));
`endif
      end
    end
  end

  // Called on a negedge; leaves the caller on the following negedge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic eo,
                       input bit push);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    if (push) sb.push_back('{ed, eb, eo, cyc + 1 + WIDTH});
    @(negedge clk);
    start_i = 1'b0;
    a_i     = ~a;
    b_i     = WIDTH'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_d",    32'(d_o),    32'd0);
    chk("rst_bout", 32'(bout_o), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf",  32'(ovf_o),  32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b1);
    drain();
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    drain();

    // start re-pulsed in RUN with different operands, then again in DONE.
    issue(8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1);
    start_i = 1'b1; a_i = 8'hFF; b_i = 8'h00;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (12) @(negedge clk);
    drain();
    chk("d_held", 32'(d_o), 32'h00);
    chk("idle_busy", 32'(busy_o), 32'd0);

    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    drain();
    chk("d_held_7f", 32'(d_o), 32'h7F);

    // Reset mid-RUN: the aborted operation must never report done.
    issue(8'h55, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_d",    32'(d_o),    32'd0);
    chk("abort_bout", 32'(bout_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_abort_busy", 32'(busy_o), 32'd0);

    issue(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);
    drain();

    // Back to back: second start lands in the first IDLE cycle after DONE.
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    issue(8'hFF, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1);
    drain();

    issue(8'h01, 8'h80, 8'h81, 1'b1, 1'b1, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned; captured on the accepted start edge.
REQ-006 b  input  WIDTH  subtrahend, unsigned; captured on the accepted start edge.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  one-cycle pulse; result is valid.
REQ-009 d  output  WIDTH  difference (a - b) mod 2^WIDTH; held until the next accepted start.
REQ-010 bout  output  1  final borrow, 1 iff a < b (unsigned); held with d.
REQ-011 ovf  output  1  signed overflow flag; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-012 FSM states: IDLE, RUN, DONE; all outputs registered.
REQ-013 IDLE with start=1 at an edge: load the a and b shift registers, clear the borrow flop and the bit counter, and go to RUN.
REQ-014 Each RUN edge processes one bit, LSB first, as a full subtractor built from two half subtractors.
REQ-015 Bit rule: diff = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-016 Each RUN edge shifts diff into the result register MSB side, shifts both operand registers right by one, and increments the counter.
REQ-017 On the WIDTH-th RUN edge:
  - go to DONE;
  - d takes the full result;
  - bout takes br_next;
  - done is set to 1.
REQ-018 The DONE edge clears done and returns to IDLE, so done is high for exactly one cycle.
REQ-019 Latency: done is high in the cycle following the WIDTH-th edge after the start edge, so the start-to-start throughput is WIDTH+2 cycles.
REQ-020 start asserted in RUN or DONE is ignored and is not queued.
REQ-021 a and b may change freely after the start edge without affecting the result.
REQ-022 d and bout update only on the DONE transition; they are stable at every other time.
REQ-023 Back-to-back operation: a start asserted in the first IDLE cycle after DONE is accepted.

Reset
REQ-024 While rst_n=0, regardless of clk:
  - state = IDLE;
  - busy, done, d, bout and ovf = 0;
  - shift registers, borrow flop and counter = 0.
REQ-025 Reset asserted mid-RUN aborts the operation with no done pulse; the first operation after release starts cleanly from IDLE.
REQ-026 Release of rst_n is synchronous to the design: the first active edge after release may accept start.

Configuration
REQ-027 Macro SERIAL_SUB_OVF_EN defined: port ovf exists and is loaded at the DONE transition as (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), using the captured operand MSBs; it is held with d.
REQ-028 Macro SERIAL_SUB_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-029 a=8'h5A, b=8'h23, start pulse -> done exactly 8 cycles after the start edge; d=8'h37, bout=0.
REQ-030 a=8'h00, b=8'h01 -> d=8'hFF, bout=1, ovf=0.
REQ-031 a=8'h80, b=8'h01 (OVF_EN defined) -> d=8'h7F, bout=0, ovf=1.
REQ-032 a=8'hC3, b=8'hC3, with start re-pulsed during RUN and a/b changed after the start edge -> one done only, d=8'h00, bout=0.
REQ-033 rst_n driven low mid-RUN (cycle 4) and then released, followed by a=8'h10, b=8'h20 -> no done from the aborted operation; new result d=8'hF0, bout=1.
REQ-034 Two back-to-back operations (second start in the first IDLE cycle after DONE) -> two done pulses 10 cycles apart, each with a correct result.
